// File: rtl/otg_hpi_arbiter.sv
// otg_hpi_arbiter: two-port round-robin sequencer for the CY7C67200 HPI bus.
// Each granted request runs a timed SETUP/STROBE/HOLD/RECOVER cycle on the pins.
module otg_hpi_arbiter #(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 2,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 1,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        busy,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RECOVER
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVERY_CYC - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_load;
    logic             cnt_reload;
    logic             grant, grant_port;
    logic             last_grant;
    logic             sel, we_l;
    logic [1:0]       addr_l;
    logic [15:0]      wdata_l;
    logic             cur_we;
    logic [1:0]       cur_addr;
    logic [15:0]      cur_wdata;
    logic             next_active;

    // Arbitration in IDLE; current transaction fields come straight from the
    // winner on the grant cycle so the pins can be registered in step with SETUP.
    always_comb begin
        grant      = 1'b0;
        grant_port = 1'b0;
        if (state == S_IDLE) begin
            if (req0 && req1) begin
                grant      = 1'b1;
                grant_port = ~last_grant;
            end else if (req0) begin
                grant      = 1'b1;
            end else if (req1) begin
                grant      = 1'b1;
                grant_port = 1'b1;
            end
        end
        cur_we    = we_l;
        cur_addr  = addr_l;
        cur_wdata = wdata_l;
        if (grant) begin
            cur_we    = grant_port ? we1 : we0;
            cur_addr  = grant_port ? addr1 : addr0;
            cur_wdata = grant_port ? wdata1 : wdata0;
        end
    end

    // Next-state logic: each state reloads the timing counter on entry and
    // advances when it reaches zero.
    always_comb begin
        next_state = state;
        cnt_reload = 1'b0;
        cnt_load   = '0;
        case (state)
            S_IDLE: if (grant) begin
                next_state = S_SETUP;
                cnt_reload = 1'b1;
                cnt_load   = SETUP_LD;
            end
            S_SETUP: if (cnt == '0) begin
                next_state = S_STROBE;
                cnt_reload = 1'b1;
                cnt_load   = STROBE_LD;
            end
            S_STROBE: if (cnt == '0) begin
                next_state = S_HOLD;
                cnt_reload = 1'b1;
                cnt_load   = HOLD_LD;
            end
            S_HOLD: if (cnt == '0) begin
                next_state = S_RECOVER;
                cnt_reload = 1'b1;
                cnt_load   = RECOVER_LD;
            end
            S_RECOVER: if (cnt == '0) begin
                next_state = S_IDLE;
                cnt_reload = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
        next_active = (next_state == S_SETUP) || (next_state == S_STROBE) ||
                      (next_state == S_HOLD);
    end

    // State register and timing counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (cnt_reload)
                cnt <= cnt_load;
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    // Latch the granted request so later changes on the port are ignored.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            last_grant <= 1'b1;
            sel        <= 1'b0;
            we_l       <= 1'b0;
            addr_l     <= '0;
            wdata_l    <= '0;
        end else if (grant) begin
            last_grant <= grant_port;
            sel        <= grant_port;
            we_l       <= cur_we;
            addr_l     <= cur_addr;
            wdata_l    <= cur_wdata;
        end
    end

    // Registered pin and handshake outputs, decoded from the upcoming state.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            busy         <= 1'b0;
            otg_cs_n     <= 1'b1;
            otg_rd_n     <= 1'b1;
            otg_wr_n     <= 1'b1;
            otg_data_oe  <= 1'b0;
            otg_addr     <= '0;
            otg_data_out <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            busy        <= (next_state != S_IDLE);
            otg_cs_n    <= ~next_active;
            otg_rd_n    <= ~((next_state == S_STROBE) && !cur_we);
            otg_wr_n    <= ~((next_state == S_STROBE) && cur_we);
            otg_data_oe <= next_active && cur_we;
            if (grant) begin
                otg_addr <= cur_addr;
                if (cur_we)
                    otg_data_out <= cur_wdata;
            end
            ack0 <= (state == S_HOLD) && (next_state == S_RECOVER) && !sel;
            ack1 <= (state == S_HOLD) && (next_state == S_RECOVER) && sel;
            if ((state == S_STROBE) && (cnt == '0) && !we_l) begin
                if (sel)
                    rdata1 <= otg_data_in;
                else
                    rdata0 <= otg_data_in;
            end
        end
    end

endmodule

// File: tb/tb_otg_hpi_arbiter.sv
// Bench for otg_hpi_arbiter: vector table plus hand sequences, acks checked
// against a scoreboard; a second instance covers non-default timing.
module tb_otg_hpi_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [1:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1, din;
    logic        ack0, ack1, busy, cs_n, rd_n, wr_n, oe;
    logic [15:0] rdata0, rdata1, dout;
    logic [1:0]  oaddr;

    logic        b_req0, b_req1, b_we0, b_we1;
    logic [1:0]  b_addr0, b_addr1;
    logic [15:0] b_wdata0, b_wdata1, b_din;
    logic        b_ack0, b_ack1, b_busy, b_cs_n, b_rd_n, b_wr_n, b_oe;
    logic [15:0] b_rdata0, b_rdata1, b_dout;
    logic [1:0]  b_oaddr;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          port;
        bit          rd;
        logic [15:0] data;
    } sb_t;
    sb_t         sb[$];
    logic [15:0] m_rd0, m_rd1;

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic [15:0] exp_rd0;
        logic [15:0] exp_rd1;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    otg_hpi_arbiter dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .otg_addr(oaddr), .otg_cs_n(cs_n), .otg_rd_n(rd_n), .otg_wr_n(wr_n),
        .otg_data_out(dout), .otg_data_oe(oe), .otg_data_in(din)
    );

    otg_hpi_arbiter #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2),
                      .RECOVERY_CYC(3), .CNT_W(4)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1), .busy(b_busy),
        .otg_addr(b_oaddr), .otg_cs_n(b_cs_n), .otg_rd_n(b_rd_n), .otg_wr_n(b_wr_n),
        .otg_data_out(b_dout), .otg_data_oe(b_oe), .otg_data_in(b_din)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle, sample 1 time unit after the edge, check bus
    // invariants on both instances and retire acks of instance A.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        chk("inv_a_rdwr", 32'(!rd_n && !wr_n), 0);
        chk("inv_a_cs", 32'((!rd_n || !wr_n) && cs_n), 0);
        chk("inv_b_rdwr", 32'(!b_rd_n && !b_wr_n), 0);
        chk("inv_b_cs", 32'((!b_rd_n || !b_wr_n) && b_cs_n), 0);
        if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
            end else begin
                e = sb.pop_front();
                chk("sb_ack_port", 32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
                if (e.rd) begin
                    if (e.port) m_rd1 = e.data;
                    else        m_rd0 = e.data;
                end
                chk("sb_rdata0", rdata0, m_rd0);
                chk("sb_rdata1", rdata1, m_rd1);
            end
        end
    endtask

    // Expected pin state for a transaction whose request was seen at rel = 0.
    task automatic check_pins(input string tag, input int rel, input int s, input int t,
                              input int h, input int r, input bit w, input logic [1:0] a,
                              input logic [15:0] d, input logic p_cs_n, input logic p_rd_n,
                              input logic p_wr_n, input logic p_oe, input logic p_busy,
                              input logic ack_this, input logic ack_other,
                              input logic [1:0] p_addr, input logic [15:0] p_dout);
        bit in_cs, stb, act;
        in_cs = (rel >= 1) && (rel <= s + t + h);
        stb   = (rel > s) && (rel <= s + t);
        act   = (rel >= 1) && (rel <= s + t + h + r);
        chk($sformatf("%s_cs_n@%0d", tag, rel), 32'(p_cs_n), 32'(!in_cs));
        chk($sformatf("%s_rd_n@%0d", tag, rel), 32'(p_rd_n), 32'(!(stb && !w)));
        chk($sformatf("%s_wr_n@%0d", tag, rel), 32'(p_wr_n), 32'(!(stb && w)));
        chk($sformatf("%s_oe@%0d", tag, rel), 32'(p_oe), 32'(in_cs && w));
        chk($sformatf("%s_busy@%0d", tag, rel), 32'(p_busy), 32'(act));
        chk($sformatf("%s_ack@%0d", tag, rel), 32'(ack_this), 32'(rel == s + t + h + 1));
        chk($sformatf("%s_ack_other@%0d", tag, rel), 32'(ack_other), 0);
        if (act) chk($sformatf("%s_addr@%0d", tag, rel), 32'(p_addr), 32'(a));
        if (in_cs && w) chk($sformatf("%s_dout@%0d", tag, rel), 32'(p_dout), 32'(d));
    endtask

    // One transaction on instance A starting in IDLE; request inputs are
    // scrambled right after grant and req drops at drop_cyc.
    task automatic run_a(input bit port, input bit w, input logic [1:0] a,
                         input logic [15:0] d, input logic [15:0] dv, input int drop_cyc);
        if (port) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else      begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        din = ~dv;
        sb.push_back('{port: port, rd: !w, data: dv});
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            check_pins(port ? "p1" : "p0", cyc, 1, 2, 1, 1, w, a, d, cs_n, rd_n, wr_n, oe,
                       busy, port ? ack1 : ack0, port ? ack0 : ack1, oaddr, dout);
            if (cyc == drop_cyc) begin
                if (port) req1 = 1'b0;
                else      req0 = 1'b0;
            end
            if (cyc == 1) begin
                if (port) begin addr1 = ~a; wdata1 = ~d; we1 = ~w; end
                else      begin addr0 = ~a; wdata0 = ~d; we0 = ~w; end
            end
            din = (cyc == 3) ? dv : ~dv;
        end
    endtask

    initial begin
        vecs[0] = '{0, 1, 2'd2, 16'h1234, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1, 0, 2'd1, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF};
        vecs[2] = '{0, 0, 2'd3, 16'h0000, 16'hA5A5, 16'hA5A5, 16'hBEEF};
        vecs[3] = '{1, 1, 2'd0, 16'hFFFF, 16'h1111, 16'hA5A5, 16'hBEEF};
        vecs[4] = '{0, 1, 2'd1, 16'h0000, 16'h2222, 16'hA5A5, 16'hBEEF};
        vecs[5] = '{1, 0, 2'd2, 16'h0000, 16'h0001, 16'hA5A5, 16'h0001};

        rst_n = 1'b0;
        {req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, din} = '0;
        {b_req0, b_req1, b_we0, b_we1, b_addr0, b_addr1, b_wdata0, b_wdata1, b_din} = '0;
        m_rd0 = '0;
        m_rd1 = '0;
        tick();
        tick();
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_rd_n", 32'(rd_n), 1);
        chk("rst_wr_n", 32'(wr_n), 1);
        chk("rst_oe", 32'(oe), 0);
        chk("rst_addr", 32'(oaddr), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_acks", 32'({ack1, ack0}), 0);
        chk("rst_rdata0", 32'(rdata0), 0);
        chk("rst_rdata1", 32'(rdata1), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Table of single transactions, each started as soon as A is idle.
        for (int i = 0; i < 6; i++) begin
            run_a(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].din, 5);
            chk($sformatf("vec%0d_rdata0", i), 32'(rdata0), 32'(vecs[i].exp_rd0));
            chk($sformatf("vec%0d_rdata1", i), 32'(rdata1), 32'(vecs[i].exp_rd1));
        end

        // Request pulsed for a single cycle still completes with latched fields.
        run_a(0, 1, 2'd3, 16'h5A5A, 16'h0000, 1);
        chk("pulse_idle_busy", 32'(busy), 0);

        // Reset during the write strobe abandons the transaction.
        run_a(1, 0, 2'd0, 16'h0000, 16'h7777, 5);
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 16'hCAFE;
        sb.push_back('{port: 0, rd: 0, data: 16'h0000});
        tick();
        tick();
        chk("mid_wr_n_low", 32'(wr_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_n", 32'(wr_n), 1);
        chk("mid_rst_cs_n", 32'(cs_n), 1);
        chk("mid_rst_oe", 32'(oe), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rdata1", 32'(rdata1), 0);
        sb.delete();
        m_rd0 = '0;
        m_rd1 = '0;
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_cs_n", 32'(cs_n), 1);
        run_a(0, 1, 2'd1, 16'h0F0F, 16'h0000, 5);

        // Both requesters held from reset: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd2; wdata1 = 16'h2222;
        for (int k = 0; k < 4; k++) sb.push_back('{port: k[0], rd: 0, data: 16'h0000});
        for (int cyc = 1; cyc <= 24; cyc++) begin
            tick();
            chk($sformatf("rr_ack0@%0d", cyc), 32'(ack0), 32'(cyc == 5 || cyc == 17));
            chk($sformatf("rr_ack1@%0d", cyc), 32'(ack1), 32'(cyc == 11 || cyc == 23));
            if (cyc == 1 || cyc == 13) begin
                chk($sformatf("rr_addr@%0d", cyc), 32'(oaddr), 1);
                chk($sformatf("rr_dout@%0d", cyc), 32'(dout), 32'h1111);
            end
            if (cyc == 7 || cyc == 19) begin
                chk($sformatf("rr_addr@%0d", cyc), 32'(oaddr), 2);
                chk($sformatf("rr_dout@%0d", cyc), 32'(dout), 32'h2222);
            end
            if (cyc == 23) begin req0 = 1'b0; req1 = 1'b0; end
        end
        chk("rr_busy_end", 32'(busy), 0);

        // Instance B, stretched timing: read on port 0, then a queued write on
        // port 1 that can only be granted once B is back in IDLE.
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 2'd1; b_din = 16'hDEAD;
        for (int cyc = 1; cyc <= 23; cyc++) begin
            tick();
            if (cyc <= 12)
                check_pins("b_rd", cyc, 3, 4, 2, 3, 0, 2'd1, 16'h0000, b_cs_n, b_rd_n,
                           b_wr_n, b_oe, b_busy, b_ack0, b_ack1, b_oaddr, b_dout);
            else
                check_pins("b_wr", cyc - 13, 3, 4, 2, 3, 1, 2'd3, 16'h7E57, b_cs_n, b_rd_n,
                           b_wr_n, b_oe, b_busy, b_ack1, b_ack0, b_oaddr, b_dout);
            if (cyc == 10) begin
                chk("b_rdata0", 32'(b_rdata0), 32'hC0DE);
                chk("b_rdata1", 32'(b_rdata1), 0);
                b_req0 = 1'b0;
            end
            if (cyc == 3) begin
                b_req1 = 1'b1; b_we1 = 1'b1; b_addr1 = 2'd3; b_wdata1 = 16'h7E57;
            end
            if (cyc == 22) b_req1 = 1'b0;
            b_din = (cyc == 7) ? 16'hC0DE : 16'hDEAD;
        end
        chk("b_rdata0_kept", 32'(b_rdata0), 32'hC0DE);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/otg_hpi_arbiter.md
Name: otg_hpi_arbiter

Overview:
- Hardware sequencer for the CY7C67200 OTG HPI bus.
- Replaces bit-banged PIO access (address/cs/r/w/data PIO ports) with timed, atomic read/write cycles.
- Shares the bus between two requesters: port 0 is the Nios-side PIO bridge, port 1 is the hardware keycode poller.
- Sits between the Qsys system and the top-level OTG pins. The top level builds the tri-state from the data_out / data_oe / data_in split.

Parameters:
- SETUP_CYC, 1, cycles from CS_N/address valid to strobe assertion (>=1)
- STROBE_CYC, 2, cycles RD_N or WR_N held low (>=1)
- HOLD_CYC, 1, cycles after strobe release with CS_N/address/data still held (>=1)
- RECOVERY_CYC, 1, cycles with CS_N high before the next transaction (>=1)
- CNT_W, 4, timing counter width; every *_CYC must be < 2^CNT_W

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge
- reset_reset_n  in  1  asynchronous, active-low reset
- req0, req1  in  1 each  request; held high until the matching ack
- we0, we1  in  1 each  1 = write, 0 = read; sampled at grant
- addr0, addr1  in  2 each  HPI register select; sampled at grant
- wdata0, wdata1  in  16 each  write data; sampled at grant
- ack0, ack1  out  1 each  one-cycle completion pulse
- rdata0, rdata1  out  16 each  read data; valid from ack onward until the next read on that port
- busy  out  1  high in every state except IDLE
- otg_addr  out  2  HPI address
- otg_cs_n, otg_rd_n, otg_wr_n  out  1 each  active-low strobes
- otg_data_out  out  16  write data
- otg_data_oe  out  1  data bus output enable
- otg_data_in  in  16  read data from the pins

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; otg_cs_n, otg_rd_n, otg_wr_n = 1.
  - otg_addr = 0, otg_data_out = 0, otg_data_oe = 0.
  - ack0, ack1 = 0; rdata0, rdata1 = 0; busy = 0; last_grant = 1.
  - An in-flight transaction is abandoned; no ack is issued.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE. A counter loads at each state entry and the state advances when the counter expires.
- IDLE, arbitration:
  - Only one requester high: it is granted.
  - Both high: grant the port != last_grant (round-robin); update last_grant.
  - On grant, latch addr/we/wdata and enter SETUP next cycle.
  - No request: remain in IDLE.
- SETUP (SETUP_CYC cycles):
  - otg_cs_n = 0; otg_addr = latched address.
  - Write: otg_data_oe = 1, otg_data_out = latched wdata.
- STROBE (STROBE_CYC cycles):
  - Read: otg_rd_n = 0. Write: otg_wr_n = 0.
  - CS_N, address and data held.
  - Read: otg_data_in is registered into the granted port's rdata on the last STROBE cycle.
- HOLD (HOLD_CYC cycles):
  - otg_rd_n = otg_wr_n = 1.
  - otg_cs_n = 0, address and otg_data_oe/otg_data_out unchanged.
- RECOVER (RECOVERY_CYC cycles):
  - otg_cs_n = 1, otg_data_oe = 0.
  - ack of the granted port = 1 in the first RECOVER cycle only.
- Rules:
  - otg_rd_n and otg_wr_n are never low simultaneously.
  - Neither strobe is ever low while otg_cs_n = 1.
  - All pin outputs are registered; no glitches.
- Latency: request seen in IDLE at cycle 0 -> ack at cycle 1+SETUP_CYC+STROBE_CYC+HOLD_CYC (5 with defaults). The next grant is evaluated at cycle ack+RECOVERY_CYC (6).
- A req dropped before ack still completes and acks; the latched fields are used.
- A req held high after ack is treated as a new request at the next IDLE.
- Changing addr/we/wdata after grant has no effect on the current transaction.
- rdata is not modified by writes or by the other port's transactions.

Test Plan:
- Port-0 write, addr=2, wdata=0x1234, defaults:
  - cs_n low at cycle 1 through cycle 4.
  - wr_n low at cycles 2-3 only; data_oe=1 and data_out=0x1234 at cycles 1-4.
  - ack0 pulse at cycle 5; busy low at cycle 6.
- Port-1 read, addr=1, otg_data_in=0xBEEF during strobe:
  - rd_n low at cycles 2-3; data_oe stays 0.
  - ack1 at cycle 5 with rdata1=0xBEEF; rdata0 unchanged.
- req0 and req1 both held high from reset:
  - Grants alternate 0,1,0,1.
  - Acks alternate, spaced 6 cycles apart (defaults).
- req0 pulsed high for a single cycle:
  - Transaction completes; ack0 pulse at cycle 5.
  - Changes to addr0 during STROBE have no effect on otg_addr.
- reset_reset_n low during STROBE of a write:
  - Asynchronously: wr_n=1, cs_n=1, data_oe=0.
  - No ack; after release, IDLE and a new req0 is granted normally.
- SETUP_CYC=3, STROBE_CYC=4, HOLD_CYC=2, RECOVERY_CYC=3:
  - Read ack at cycle 10; next grant evaluated at cycle 13.
  - The rd_n/cs_n invariants hold throughout.
